// File: rtl/config_loader.sv
// Serial configuration loader: shifts a WIDTH-bit word LSB first into the core over sen/sclk/sdata.
// Define CONFIG_LOADER_RELOAD_EN to allow reloading cfg_word after the reset-time DEFAULT_CFG transfer.
module config_loader #(
    parameter int               WIDTH       = 33,
    parameter logic [WIDTH-1:0] DEFAULT_CFG = 33'h03CF10404,
    parameter int               SCLK_DIV    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cfg_word,
    input  logic             reload,
    output logic             sen,
    output logic             sdata,
    output logic             sclk,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift;
    logic             div_last;
    logic             bit_last;

    // Handshake: reload is a one-cycle pulse; it is remembered until the next LOAD consumes it.
`ifdef CONFIG_LOADER_RELOAD_EN
    logic pending;
`else
    logic unused_inputs;
    assign unused_inputs = ^{reload, cfg_word};
`endif

    assign div_last  = (div_cnt == 8'(SCLK_DIV - 1));
    assign bit_last  = (bit_cnt == BW'(WIDTH - 1));
    assign sdata     = shift[0];
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        case (state)
            S_LOAD:  state_next = S_SETUP;
            S_SETUP: if (div_last) state_next = S_HIGH;
            S_HIGH:  if (div_last) state_next = S_LOW;
            S_LOW:   if (div_last) state_next = bit_last ? S_DONE : S_HIGH;
            S_DONE: begin
`ifdef CONFIG_LOADER_RELOAD_EN
                if (pending || reload) state_next = S_LOAD;
`endif
            end
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_LOAD;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            sen     <= 1'b0;
            sclk    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef CONFIG_LOADER_RELOAD_EN
            pending <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            div_cnt <= (state_next != state) ? 8'd0 : div_cnt + 8'd1;

            case (state)
                S_LOAD: begin
`ifdef CONFIG_LOADER_RELOAD_EN
                    shift <= pending ? cfg_word : DEFAULT_CFG;
`else
                    shift <= DEFAULT_CFG;
`endif
                    bit_cnt <= '0;
                end
                // Shift on the falling sclk edge so sdata is stable around every rising edge.
                S_HIGH: if (div_last) shift <= shift >> 1;
                S_LOW:  if (div_last && !bit_last) bit_cnt <= bit_cnt + BW'(1);
                default: ;
            endcase

`ifdef CONFIG_LOADER_RELOAD_EN
            if (state == S_LOAD) pending <= reload;
            else if (reload)     pending <= 1'b1;
`endif

            // Outputs are registered from the next state so they line up with the state they describe.
            sen  <= (state_next == S_SETUP) || (state_next == S_HIGH) || (state_next == S_LOW);
            sclk <= (state_next == S_HIGH);
            busy <= (state_next != S_DONE);
            done <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (SCLK_DIV 1 and 3) checked every cycle against a transfer-offset model.
`timescale 1ns/1ps
module tb_config_loader;

    localparam int             W   = 33;
    localparam logic [W-1:0]   DEF = 33'h03CF10404;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         reload = 1'b0;
    logic [W-1:0] cfg_word = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int DIV     = (g == 0) ? 1 : 3;
        localparam int L       = 1 + DIV * (1 + 2 * W);
        localparam int SEN_LIT = (g == 0) ? 67 : 201;

        logic       sen, sdata, sclk, busy, done;
        logic [2:0] dbg_state;

        config_loader #(.WIDTH(W), .DEFAULT_CFG(DEF), .SCLK_DIV(DIV)) dut (
            .clk(clk), .reset(reset), .cfg_word(cfg_word), .reload(reload),
            .sen(sen), .sdata(sdata), .sclk(sclk), .busy(busy), .done(done),
            .dbg_state(dbg_state)
        );

        // Model: off = cycles since the LOAD cycle of the current transfer, L = idle/done.
        int           off = 0;
        bit           in_rst = 1'b1;
        bit           pend = 1'b0;
        logic [W-1:0] word = '0;
        logic [W-1:0] exp_q[$];

        always @(posedge clk) begin
            if (reset) begin
                off = 0;
                in_rst = 1'b1;
                pend = 1'b0;
                exp_q.delete();
            end else if (off == 0) begin
                word = pend ? cfg_word : DEF;
                exp_q.push_back(word);
`ifdef CONFIG_LOADER_RELOAD_EN
                pend = reload;
`endif
                off = 1;
                in_rst = 1'b0;
            end else if (off < L) begin
`ifdef CONFIG_LOADER_RELOAD_EN
                if (reload) pend = 1'b1;
`endif
                off++;
            end else begin
`ifdef CONFIG_LOADER_RELOAD_EN
                if (pend || reload) begin
                    pend = 1'b1;
                    off = 0;
                end
`endif
            end
        end

        // {sen, sclk, sdata, busy, done} at a given transfer offset
        function automatic logic [4:0] expect_out(int o, bit ir, logic [W-1:0] w);
            int k, j, b, ph;
            if (o == 0) return {3'b000, ~ir, 1'b0};
            if (o >= L) return 5'b00001;
            k = o - 1;
            if (k < DIV) return {1'b1, 1'b0, w[0], 1'b1, 1'b0};
            j  = k - DIV;
            b  = j / (2 * DIV);
            ph = j % (2 * DIV);
            if (ph < DIV) return {1'b1, 1'b1, w[b], 1'b1, 1'b0};
            return {1'b1, 1'b0, (b + 1 < W) ? w[b + 1] : 1'b0, 1'b1, 1'b0};
        endfunction

        logic [W-1:0] cap = '0;
        int           cap_n = 0;
        int           sen_run = 0;
        bit           first_after_rst = 1'b1;
        logic         prev_sclk = 1'b0;
        logic         prev_sdata = 1'b0;
        logic [W-1:0] ew;

        always @(negedge clk) begin
            check($sformatf("outs_div%0d", DIV), {59'd0, sen, sclk, sdata, busy, done},
                  {59'd0, expect_out(off, in_rst, word)});
            if (reset) begin
                cap_n = 0;
                sen_run = 0;
                first_after_rst = 1'b1;
            end else begin
                if (sclk) check($sformatf("sdata_stable_div%0d", DIV), {63'd0, sdata}, {63'd0, prev_sdata});
                if (sclk && !prev_sclk) begin
                    cap[cap_n] = sdata;
                    cap_n++;
                    if (cap_n == W) begin
                        if (exp_q.size() == 0) begin
                            check($sformatf("unexpected_word_div%0d", DIV), 64'(cap), 64'hDEAD);
                        end else begin
                            ew = exp_q.pop_front();
                            check($sformatf("word_div%0d", DIV), 64'(cap), 64'(ew));
                        end
                        if (first_after_rst) begin
                            check($sformatf("first_word_lit_div%0d", DIV), 64'(cap), 64'h0_03CF_10404);
                            first_after_rst = 1'b0;
                        end
                        cap_n = 0;
                    end
                end
                if (sen) sen_run++;
                else if (sen_run > 0) begin
                    check($sformatf("sen_len_div%0d", DIV), 64'(sen_run), 64'(SEN_LIT));
                    sen_run = 0;
                end
            end
            prev_sclk  = sclk;
            prev_sdata = sdata;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Wait until both instances have sat in DONE for several consecutive cycles.
    task automatic wait_quiet(input int budget);
        int c = 0;
        int q = 0;
        while (q < 5 && c < budget) begin
            tick();
            c++;
            if (inst[0].done && inst[1].done) q++;
            else q = 0;
        end
        check("wait_quiet_timeout", 64'(c < budget), 64'd1);
    endtask

    initial begin
        int rises;
        int c;
        logic prev;

        // Reset state
        tick(3);
        check("reset_outs0", {59'd0, inst[0].sen, inst[0].sclk, inst[0].sdata, inst[0].busy, inst[0].done}, 64'd0);
        reset = 1'b0;

        // Automatic DEFAULT_CFG transfer after reset
        wait_quiet(1000);
        check("done_after_first", 64'(inst[0].done), 64'd1);
        tick(20);

        // Reload request in DONE
        cfg_word = 33'h1_2345_6789;
        reload = 1'b1;
        tick();
        reload = 1'b0;
`ifdef CONFIG_LOADER_RELOAD_EN
        check("reload_to_load_busy", 64'(inst[0].busy), 64'd1);
`else
        check("reload_ignored_done", 64'(inst[0].done), 64'd1);
        tick(1000);
        check("done_held_1000", 64'(inst[0].done), 64'd1);
`endif
        wait_quiet(2000);

        // Start a transfer, then three reload pulses during it
        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick(10);
        for (int i = 0; i < 3; i++) begin
            cfg_word = W'({$urandom(), $urandom()});
            reload = 1'b1;
            tick();
            reload = 1'b0;
            tick($urandom_range(2, 15));
        end
        wait_quiet(3000);

        // Reset at the 10th sclk rising edge of a fresh transfer
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rises = 0;
        c = 0;
        prev = 1'b0;
        while (rises < 10 && c < 500) begin
            tick();
            c++;
            if (inst[0].sclk && !prev) rises++;
            prev = inst[0].sclk;
        end
        check("tenth_edge_timeout", 64'(rises), 64'd10);
        reset = 1'b1;
        tick();
        check("abort_outs0", {59'd0, inst[0].sen, inst[0].sclk, inst[0].sdata, inst[0].busy, inst[0].done}, 64'd0);
        reset = 1'b0;
        wait_quiet(1000);

        // Random reloads, words and occasional resets
        for (int i = 0; i < 1500; i++) begin
            cfg_word = W'({$urandom(), $urandom()});
            reload = ($urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reload = 1'b0;
        reset = 1'b0;
        wait_quiet(3000);

        check("leftover_q_div1", 64'(inst[0].exp_q.size()), 64'd0);
        check("leftover_q_div3", 64'(inst[1].exp_q.size()), 64'd0);
        check("partial_div1", 64'(inst[0].cap_n), 64'd0);
        check("partial_div3", 64'(inst[1].cap_n), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter WIDTH, default 33: configuration word length in bits.
REQ-002 Parameter DEFAULT_CFG, default 33'h03CF10404: word shifted out after reset.
REQ-003 Parameter SCLK_DIV, default 1: clk cycles per sclk half-period, legal range 1..255.
REQ-004 clk  input  1  rising-edge system clock (VGA pixel clock domain).
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_word  input  WIDTH  replacement configuration word, sampled only in LOAD after a reload request.
REQ-007 reload  input  1  single-cycle request to shift cfg_word into the core.
REQ-008 sen  output  1  serial enable to the mandelbrot core (ui_in[0]).
REQ-009 sdata  output  1  serial data, LSB first (ui_in[1]).
REQ-010 sclk  output  1  serial clock; the core samples sdata on the rising edge (ui_in[2]).
REQ-011 busy  output  1  high while a transfer is in progress.
REQ-012 done  output  1  high while in DONE state.

Function
REQ-013 States SHALL be LOAD, SETUP, HIGH, LOW, DONE; all outputs SHALL be registered, sdata = shift[0].
REQ-014 LOAD (1 cycle): shift <= DEFAULT_CFG, or cfg_word if a reload is pending; bit counter <= 0; sen=0, sclk=0, busy=1; next SETUP.
REQ-015 SETUP: sen=1, sclk=0 for SCLK_DIV cycles; next HIGH.
REQ-016 HIGH: sclk=1 for SCLK_DIV cycles; on exit shift >>= 1, sclk <= 0; next LOW.
REQ-017 LOW: sclk=0 for SCLK_DIV cycles; on exit, if counter == WIDTH-1 go to DONE, else counter+1 and go to HIGH.
REQ-018 Exactly WIDTH sclk rising edges per transfer; sdata SHALL change only on the sclk falling edge, stable across each rising edge.
REQ-019 sen SHALL be high for exactly SCLK_DIV*(1+2*WIDTH) consecutive cycles per transfer.
REQ-020 DONE: sen=0, sclk=0, busy=0, done=1; remains until a reload is pending, then goes to LOAD.
REQ-021 reload asserted while busy SHALL set a single pending flag (further pulses coalesce); honoured after one cycle in DONE.
REQ-022 reload and entry into DONE in the same cycle SHALL be treated as pending, not lost.
REQ-023 Half-period counter SHALL be 8 bits, reset to 0 at each state entry; bit counter SHALL be clog2(WIDTH+1) bits.

Reset
REQ-024 While reset=1: state=LOAD, shift=0, counters=0, pending=0, sen=0, sclk=0, sdata=0, busy=0, done=0.
REQ-025 Reset mid-transfer SHALL abort immediately; after release the transfer restarts from LOAD with DEFAULT_CFG.
REQ-026 First cycle after reset release SHALL be LOAD (automatic transfer of DEFAULT_CFG, no request needed).

Configuration
REQ-027 Macro CONFIG_LOADER_RELOAD_EN defined: reload/cfg_word behave per REQ-006, REQ-014, REQ-020..022.
REQ-028 Macro undefined: reload and cfg_word ignored, pending flag absent, DONE terminal until reset; only DEFAULT_CFG ever shifted.

Verification
REQ-029 WIDTH=33, SCLK_DIV=1, release reset -> 33 sclk rising edges, captured bits equal 33'h03CF10404 LSB first, sen high 67 cycles, done=1 afterwards.
REQ-030 SCLK_DIV=3 -> sclk high 3 / low 3 cycles, sen high 201 cycles, sdata never toggles while sclk=1.
REQ-031 Macro defined, cfg_word=33'h1_2345_6789, reload pulse in DONE -> LOAD next cycle, captured word 33'h1_2345_6789.
REQ-032 Macro defined, three reload pulses during transfer -> exactly one additional transfer after DONE.
REQ-033 Reset asserted at 10th sclk edge -> all outputs 0 next cycle; after release full DEFAULT_CFG transfer, no partial word.
REQ-034 Macro undefined, reload pulse in DONE -> no sclk activity for 1000 cycles, done stays 1.
